imem_boot_loader: RTL and testbench

- Serial program loader upstream of the single-cycle core's instruction memory.
- Takes a byte stream from the UART receiver, assembles little-endian 32-bit instructions and drives the instruction-memory write port.
- Holds the core stopped until a complete load has passed its checksum, then releases it with cpu_run.
- Replaces hard-coded memory init for FPGA bring-up.

---
 rtl/imem_boot_loader_if.sv | 33 +++
 rtl/imem_boot_loader.sv | 218 +++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the byte stream coming from the UART receiver and the instruction-
// memory write port driven by the boot loader.
//   rx_valid   : one-cycle strobe, rx_data holds a new byte
//   rx_data    : received byte
//   rx_error   : one-cycle UART framing-error strobe
//   imem_we    : instruction-memory write enable (one-cycle pulse)
//   imem_waddr : word address of the write
//   imem_wdata : 32-bit instruction word
// modport master : the side that supplies bytes and observes writes
// modport slave  : the boot loader itself
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_error;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport master (
      output rx_valid, rx_data, rx_error,
      input  imem_we, imem_waddr, imem_wdata
   );

   modport slave (
      input  rx_valid, rx_data, rx_error,
      output imem_we, imem_waddr, imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Serial program loader for the instruction memory. Frames arrive as
//    SYNC_BYTE, len_lo, len_hi, 4*len data bytes (LSB first), csum
// where csum is the mod-256 sum of len_lo, len_hi and every data byte.
// Each completed word is written to instruction memory immediately; the core
// is only released (cpu_run) once the checksum byte matches.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : byte stream in / imem write port out (slave modport)
//   reload   : one-cycle request to go back to IDLE and stop the core
//   cpu_run  : 1 = core may run
//   busy     : 1 while a frame is being received (LEN_LO..CSUM)
//   load_err : 1 while in the error state
// ---------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int         ADDR_W         = 8,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   imem_boot_loader_if.slave bus,
   input  logic              reload,
   output logic              cpu_run,
   output logic              busy,
   output logic              load_err
);

   // word_idx needs one extra bit so that len == 2^ADDR_W can be counted out.
   localparam int IDX_W = ADDR_W + 1;
   // Common width for comparing the 16-bit length with word_idx / 2^ADDR_W.
   localparam int CMP_W = (IDX_W > 17) ? IDX_W : 17;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CMP_W-1:0] MAX_LEN  = CMP_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } state_t;

   state_t             state_reg, state_next;
   logic [15:0]        len_reg, len_next;
   logic [7:0]         csum_reg, csum_next;
   logic [IDX_W-1:0]   word_idx_reg, word_idx_next;
   logic [1:0]         byte_idx_reg, byte_idx_next;
   logic [TMO_W-1:0]   tmo_reg, tmo_next;
   logic               we_reg, we_next;
   logic [ADDR_W-1:0]  waddr_reg, waddr_next;
   logic [31:0]        wdata_reg, wdata_next;
   logic [7:0]         lane_reg [0:2];

   logic               byte_ok;
   logic               in_frame;
   logic               lane_en;
   logic               clear_frame;
   logic [15:0]        len_full;
   logic [IDX_W-1:0]   word_inc;

   // A byte that arrives together with a framing error is discarded.
   assign byte_ok  = bus.rx_valid & ~bus.rx_error;
   assign in_frame = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                     (state_reg == ST_DATA)   || (state_reg == ST_CSUM);
   assign len_full = {bus.rx_data, len_reg[7:0]};
   assign word_inc = word_idx_reg + IDX_W'(1);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         len_reg      <= '0;
         csum_reg     <= '0;
         word_idx_reg <= '0;
         byte_idx_reg <= '0;
         tmo_reg      <= '0;
         we_reg       <= 1'b0;
         waddr_reg    <= '0;
         wdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         csum_reg     <= csum_next;
         word_idx_reg <= word_idx_next;
         byte_idx_reg <= byte_idx_next;
         tmo_reg      <= tmo_next;
         we_reg       <= we_next;
         waddr_reg    <= waddr_next;
         wdata_reg    <= wdata_next;
      end
   end

   // ------------------------------------------------------------------------
   // Byte-lane assembly: lanes 0..2 are held here, lane 3 comes straight from
   // rx_data when the word is written out.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               lane_reg[gi] <= '0;
            end else if (lane_en && (byte_idx_reg == 2'(gi))) begin
               lane_reg[gi] <= bus.rx_data;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic. Priority: reload > rx_error > accepted byte > timeout.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      csum_next     = csum_reg;
      word_idx_next = word_idx_reg;
      byte_idx_next = byte_idx_reg;
      tmo_next      = tmo_reg;
      we_next       = 1'b0;
      waddr_next    = waddr_reg;
      wdata_next    = wdata_reg;
      lane_en       = 1'b0;
      clear_frame   = 1'b0;

      if (reload) begin
         // Also leaves we_next at 0, cancelling a write this cycle would start.
         state_next = ST_IDLE;
      end else if (in_frame && bus.rx_error) begin
         state_next = ST_ERR;
      end else if (byte_ok) begin
         case (state_reg)
            ST_IDLE, ST_ERR: begin
               if (bus.rx_data == SYNC_BYTE) begin
                  state_next  = ST_LEN_LO;
                  clear_frame = 1'b1;
               end
            end
            ST_LEN_LO: begin
               len_next[7:0] = bus.rx_data;
               csum_next     = csum_reg + bus.rx_data;
               state_next    = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_next[15:8] = bus.rx_data;
               csum_next      = csum_reg + bus.rx_data;
               if (CMP_W'(len_full) > MAX_LEN) begin
                  state_next = ST_ERR;
               end else if (len_full == 16'd0) begin
                  state_next = ST_CSUM;
               end else begin
                  state_next    = ST_DATA;
                  word_idx_next = '0;
                  byte_idx_next = '0;
               end
            end
            ST_DATA: begin
               csum_next = csum_reg + bus.rx_data;
               if (byte_idx_reg == 2'd3) begin
                  we_next       = 1'b1;
                  waddr_next    = word_idx_reg[ADDR_W-1:0];
                  wdata_next    = {bus.rx_data, lane_reg[2], lane_reg[1], lane_reg[0]};
                  word_idx_next = word_inc;
                  byte_idx_next = 2'd0;
                  if (CMP_W'(word_inc) == CMP_W'(len_reg)) begin
                     state_next = ST_CSUM;
                  end
               end else begin
                  lane_en       = 1'b1;
                  byte_idx_next = byte_idx_reg + 2'd1;
               end
            end
            ST_CSUM: begin
               state_next = (bus.rx_data == csum_reg) ? ST_RUN : ST_ERR;
            end
            default: begin
               // RUN ignores incoming bytes.
            end
         endcase
      end else if (in_frame && (tmo_reg == TMO_LAST)) begin
         state_next = ST_ERR;
      end

      // Every new frame starts from a clean checksum, length and position.
      if (clear_frame) begin
         len_next      = '0;
         csum_next     = '0;
         word_idx_next = '0;
         byte_idx_next = '0;
      end

      // Idle-gap counter: restarts on any byte or state change.
      if ((state_next != state_reg) || byte_ok) begin
         tmo_next = '0;
      end else if (in_frame) begin
         tmo_next = tmo_reg + TMO_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.imem_we    = we_reg;
   assign bus.imem_waddr = waddr_reg;
   assign bus.imem_wdata = wdata_reg;
   assign cpu_run        = (state_reg == ST_RUN);
   assign busy           = in_frame;
   assign load_err       = (state_reg == ST_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Cycle-level vector table, hand-written corner sequences, and randomized
// frames checked against a frame-level model of the loader.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;
   localparam int ADDR_W = 8;
   localparam int TMO    = 16;

   // Expected flag nibble: {busy, cpu_run, load_err, imem_we}
   localparam logic [3:0] F_I  = 4'b0000;
   localparam logic [3:0] F_B  = 4'b1000;
   localparam logic [3:0] F_BW = 4'b1001;
   localparam logic [3:0] F_R  = 4'b0100;
   localparam logic [3:0] F_E  = 4'b0010;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic reload = 1'b0;
   logic cpu_run, busy, load_err;

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TMO),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .reload(reload),
      .cpu_run(cpu_run),
      .busy(busy),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        e;
      logic        rl;
      logic [3:0]  f;
      logic [7:0]  ea;
      logic [31:0] ed;
   } vec_t;

   wr_t  wq[$];
   vec_t tbl[$];

   // Write monitor: the pulse is one cycle wide, so each write is seen once.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) wq.push_back('{bus.imem_waddr, bus.imem_wdata});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic e, input logic rl);
      @(negedge clk);
      bus.rx_valid = v;
      bus.rx_data  = d;
      bus.rx_error = e;
      reload       = rl;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic sample;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] flags();
      return {busy, cpu_run, load_err, bus.imem_we};
   endfunction

   task automatic add(input logic v, input logic [7:0] d, input logic e, input logic rl,
                      input logic [3:0] f, input logic [7:0] ea, input logic [31:0] ed);
      tbl.push_back('{v, d, e, rl, f, ea, ed});
   endtask

   task automatic addb(input logic [7:0] d, input logic [3:0] f);
      add(1'b1, d, 1'b0, 1'b0, f, 8'h00, 32'h0);
   endtask

   // Two-word frame; good checksum is 0x02+0x13+0x05+0x93+0x05+0x10 = 0xC2.
   task automatic nominal_rows(input logic [7:0] cs, input logic [3:0] final_f);
      addb(8'hA5, F_B); addb(8'h02, F_B); addb(8'h00, F_B);
      addb(8'h13, F_B); addb(8'h05, F_B); addb(8'h00, F_B);
      add(1'b1, 8'h00, 1'b0, 1'b0, F_BW, 8'd0, 32'h00000513);
      addb(8'h93, F_B); addb(8'h05, F_B); addb(8'h10, F_B);
      add(1'b1, 8'h00, 1'b0, 1'b0, F_BW, 8'd1, 32'h00100593);
      addb(cs, final_f);
   endtask

   initial begin
      logic [7:0] big[$];
      logic [7:0] fb[$];
      wr_t        exp_q[$];
      logic [7:0] sum;
      logic [7:0] jb;
      logic [63:0] act, exp;
      int len, err_pos, accepted, nwords, nj;
      logic oversize, good, exp_run;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_error = 1'b0;

      // ---------------- reset state ----------------
      #12;
      check("reset_outputs", 64'({flags(), bus.imem_waddr, bus.imem_wdata}), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // ---------------- vector table ----------------
      addb(8'h13, F_I);                     // junk in IDLE ignored
      nominal_rows(8'hC2, F_R);
      addb(8'hA5, F_R);                     // bytes ignored in RUN
      add(1'b0, 8'h00, 1'b0, 1'b1, F_I, 8'h00, 32'h0);
      nominal_rows(8'hC3, F_E);             // bad checksum, writes still happen
      nominal_rows(8'hC2, F_R);             // recovery straight from ERR
      add(1'b0, 8'h00, 1'b0, 1'b1, F_I, 8'h00, 32'h0);
      addb(8'hA5, F_B); addb(8'h00, F_B); addb(8'h00, F_B); addb(8'h00, F_R);  // zero length
      add(1'b0, 8'h00, 1'b0, 1'b1, F_I, 8'h00, 32'h0);
      addb(8'hA5, F_B); addb(8'h01, F_B); addb(8'h01, F_E);                    // len 257
      addb(8'hA5, F_B); addb(8'h00, F_B); addb(8'h01, F_B); addb(8'h77, F_B);  // len 256 -> DATA
      addb(8'h11, F_B); addb(8'h22, F_B);
      add(1'b0, 8'h00, 1'b1, 1'b0, F_E, 8'h00, 32'h0);                         // rx_error in DATA
      addb(8'h33, F_E); addb(8'h44, F_E);                                      // no write follows
      addb(8'hA5, F_B);
      add(1'b1, 8'h00, 1'b1, 1'b0, F_E, 8'h00, 32'h0);                         // error beats byte
      add(1'b1, 8'hA5, 1'b0, 1'b1, F_I, 8'h00, 32'h0);                         // reload beats sync
      addb(8'h02, F_I);
      addb(8'hA5, F_B); addb(8'h01, F_B); addb(8'h00, F_B);
      addb(8'hAA, F_B); addb(8'hBB, F_B); addb(8'hCC, F_B);
      add(1'b1, 8'hDD, 1'b0, 1'b1, F_I, 8'h00, 32'h0);                         // reload cancels write
      add(1'b0, 8'h00, 1'b0, 1'b0, F_I, 8'h00, 32'h0);
      add(1'b0, 8'h00, 1'b1, 1'b0, F_I, 8'h00, 32'h0);                         // rx_error in IDLE

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].rl);
         sample();
         act = {28'd0, flags(), bus.imem_we ? bus.imem_waddr : 8'h00,
                bus.imem_we ? bus.imem_wdata : 32'h0};
         exp = {28'd0, tbl[i].f, tbl[i].f[0] ? tbl[i].ea : 8'h00,
                tbl[i].f[0] ? tbl[i].ed : 32'h0};
         check($sformatf("vec%0d", i), act, exp);
         $display("vec %0d: v=%0b d=%h e=%0b rl=%0b flags=%b", i, tbl[i].v, tbl[i].d,
                  tbl[i].e, tbl[i].rl, flags());
      end

      // ---------------- timeout: ERR after 16 idle cycles ----------------
      step(1'b0, 8'h00, 1'b0, 1'b1);
      send(8'hA5);
      send(8'h02);
      idle(15);
      sample();
      check("timeout_not_yet", 64'({busy, load_err}), 64'(2'b10));
      idle(1);
      sample();
      check("timeout_fires", 64'({busy, load_err}), 64'(2'b01));
      $display("seq timeout: busy=%0b load_err=%0b", busy, load_err);

      // ---------------- timeout: byte in the last cycle wins ----------------
      step(1'b0, 8'h00, 1'b0, 1'b1);
      send(8'hA5);
      send(8'h02);
      idle(15);
      send(8'h00);
      sample();
      check("timeout_byte_wins", 64'({busy, load_err}), 64'(2'b10));
      $display("seq timeout_byte_wins: busy=%0b load_err=%0b", busy, load_err);

      // ---------------- async reset mid-DATA with a write pending ----------------
      step(1'b0, 8'h00, 1'b0, 1'b1);
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      sample();
      check("write_latency", 64'({bus.imem_we, bus.imem_waddr, bus.imem_wdata}),
            64'({1'b1, 8'd0, 32'h44332211}));
      reset = 1'b0;
      #1;
      check("async_reset", 64'({flags(), bus.imem_waddr, bus.imem_wdata}), 64'd0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      reset = 1'b1;
      send(8'h13);
      sample();
      check("post_reset_junk", 64'(flags()), 64'(F_I));
      send(8'hA5);
      sample();
      check("post_reset_sync", 64'(flags()), 64'(F_B));
      $display("seq async_reset: flags=%b", flags());

      // ---------------- 256-word back-to-back frame ----------------
      step(1'b0, 8'h00, 1'b0, 1'b1);
      idle(2);
      wq.delete();
      big.delete();
      sum = 8'h01;
      for (int k = 0; k < 1024; k++) begin
         big.push_back(8'($urandom));
         sum = sum + big[k];
      end
      send(8'hA5); send(8'h00); send(8'h01);
      foreach (big[k]) send(big[k]);
      send(sum);
      idle(3);
      check("b2b_count", 64'(wq.size()), 64'd256);
      if (wq.size() == 256) begin
         for (int w = 0; w < 256; w++) begin
            check($sformatf("b2b_word%0d", w), 64'({wq[w].addr, wq[w].data}),
                  64'({8'(w), big[4*w+3], big[4*w+2], big[4*w+1], big[4*w]}));
         end
      end
      check("b2b_run", 64'(flags()), 64'(F_R));
      $display("seq b2b: writes=%0d flags=%b", wq.size(), flags());

      // ---------------- randomized frames vs frame-level model ----------------
      for (int f = 0; f < 40; f++) begin
         fb.delete();
         exp_q.delete();
         len = ($urandom_range(0, 7) == 7) ? 256 + $urandom_range(1, 300) : $urandom_range(0, 6);
         oversize = (len > 256);
         good = ($urandom_range(0, 9) < 7);
         fb.push_back(len[7:0]);
         fb.push_back(len[15:8]);
         if (!oversize) begin
            for (int k = 0; k < 4 * len; k++) fb.push_back(8'($urandom));
            sum = 8'h00;
            foreach (fb[k]) sum = sum + fb[k];
            fb.push_back(good ? sum : sum + 8'($urandom_range(1, 255)));
         end
         err_pos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, fb.size() - 1) : -1;

         // Model: bytes before the error (or all) are accepted; every complete
         // group of four data bytes is one write at its word index.
         accepted = (err_pos < 0) ? fb.size() : err_pos;
         nwords = 0;
         if (!oversize && accepted > 2) begin
            nwords = (accepted - 2) / 4;
            if (nwords > len) nwords = len;
         end
         for (int w = 0; w < nwords; w++) begin
            exp_q.push_back('{8'(w), {fb[2+4*w+3], fb[2+4*w+2], fb[2+4*w+1], fb[2+4*w]}});
         end
         exp_run = !oversize && (err_pos < 0) && good;

         step(1'b0, 8'h00, 1'b0, 1'b1);
         idle(2);
         wq.delete();
         nj = $urandom_range(0, 2);
         for (int k = 0; k < nj; k++) begin
            jb = 8'($urandom);
            if (jb == 8'hA5) jb = 8'h5A;
            send(jb);
         end
         send(8'hA5);
         for (int j = 0; j < fb.size(); j++) begin
            if (j == err_pos) begin
               step(1'($urandom), 8'($urandom), 1'b1, 1'b0);
               break;
            end
            send(fb[j]);
            idle($urandom_range(0, 3));
         end
         idle(3);

         check($sformatf("rnd%0d_count", f), 64'(wq.size()), 64'(exp_q.size()));
         if (wq.size() == exp_q.size()) begin
            foreach (exp_q[w]) begin
               check($sformatf("rnd%0d_w%0d", f, w), 64'({wq[w].addr, wq[w].data}),
                     64'({exp_q[w].addr, exp_q[w].data}));
            end
         end
         check($sformatf("rnd%0d_flags", f), 64'(flags()),
               64'(exp_run ? F_R : F_E));
         $display("rnd %0d: len=%0d good=%0b err_pos=%0d writes=%0d flags=%b",
                  f, len, good, err_pos, wq.size(), flags());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
